// File: rtl/pwm_capture_if.sv
// pwm_capture_if: bundles the PWM input and the measurement result of
// pwm_capture.
//   pwm_in      : asynchronous PWM input (into the capture block)
//   high_time   : high cycles of the last complete period (saturated)
//   period      : cycles between the last two rising edges (saturated)
//   valid       : one-cycle strobe, result updated this cycle
//   overflow    : a counter saturated during the current result
//   timeout     : level, no edge seen for TIMEOUT cycles
//   stuck_level : synchronised input level captured when timeout asserted
// master = the capture block, slave = the consumer that drives pwm_in.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             overflow;
  logic             timeout;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output high_time, period, valid, overflow, timeout, stuck_level
  );

  modport slave (
    output pwm_in,
    input  high_time, period, valid, overflow, timeout, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform.
// pwm_in is synchronised, edges are detected, and clk cycles are counted
// for the high time and for the full rising-to-rising period. Each
// completed period is published with a one-cycle valid strobe. A stalled
// input (no edge for TIMEOUT cycles) raises the timeout level.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : pwm_capture_if.master (pwm_in in; measurement results out)
// Parameters:
//   CNT_W       : width of high_time/period counters and outputs
//   SYNC_STAGES : pwm_in synchroniser depth, 2..4
//   TIMEOUT     : edge-free cycles before timeout, 1 .. 2^24-1
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input logic           clk,
  input logic           rst,
  pwm_capture_if.master bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             overflow;
  } meas_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [23:0]      IDLE_LIM = 24'(TIMEOUT - 1);
  localparam logic [23:0]      IDLE_MAX = 24'hFF_FFFF;

  // input synchroniser and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, prev, rise, fall, edge_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      prev   <= s;
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~prev;
  assign fall     = ~s & prev;
  assign edge_det = rise | fall;

  // measurement state
  state_t           state, state_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt, per_cnt, per_nxt;
  logic             ovf_acc, ovf_nxt;
  logic [23:0]      idle_cnt;
  logic             hi_sat, per_sat, tmo_hit, publish;
  logic [CNT_W-1:0] hi_inc, per_inc;

  // result registers
  meas_t meas_q;
  logic  valid_q, timeout_q, stuck_q;

  always_comb begin
    hi_sat  = (hi_cnt == CNT_MAX);
    per_sat = (per_cnt == CNT_MAX);
    hi_inc  = hi_sat  ? hi_cnt  : hi_cnt + CNT_ONE;
    per_inc = per_sat ? per_cnt : per_cnt + CNT_ONE;
    // an edge on the same cycle always beats the timeout
    tmo_hit = ~edge_det && (idle_cnt == IDLE_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_cnt;
    per_nxt   = per_cnt;
    ovf_nxt   = ovf_acc;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        // only a rise opens a measurement; a fall here is just an edge
        if (rise) begin
          state_nxt = HIGH;
          hi_nxt    = CNT_ONE;
          per_nxt   = CNT_ONE;
          ovf_nxt   = 1'b0;
        end
      end
      HIGH: begin
        per_nxt = per_inc;
        ovf_nxt = ovf_acc | per_sat;
        if (fall) begin
          // hi_cnt already holds the full high count on the fall cycle
          state_nxt = LOW;
        end else begin
          hi_nxt  = hi_inc;
          ovf_nxt = ovf_acc | per_sat | hi_sat;
        end
      end
      LOW: begin
        if (rise) begin
          // closing rise: publish and open the next period on one edge.
          // No increment happens on this edge, so ovf_acc is complete.
          publish   = 1'b1;
          state_nxt = HIGH;
          hi_nxt    = CNT_ONE;
          per_nxt   = CNT_ONE;
          ovf_nxt   = 1'b0;
        end else begin
          per_nxt = per_inc;
          ovf_nxt = ovf_acc | per_sat;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // a stalled input abandons any open measurement
    if (tmo_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt   <= '0;
      per_cnt  <= '0;
      ovf_acc  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      hi_cnt   <= hi_nxt;
      per_cnt  <= per_nxt;
      ovf_acc  <= ovf_nxt;
      if (edge_det)                 idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      valid_q <= publish;
      if (publish) begin
        meas_q.high_time <= hi_cnt;
        meas_q.period    <= per_cnt;
        meas_q.overflow  <= ovf_acc;
      end
      if (edge_det) begin
        timeout_q <= 1'b0;
      end else if (tmo_hit) begin
        timeout_q <= 1'b1;
        stuck_q   <= s;
      end
    end
  end

  assign bus.high_time   = meas_q.high_time;
  assign bus.period      = meas_q.period;
  assign bus.overflow    = meas_q.overflow;
  assign bus.valid       = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.stuck_level = stuck_q;

endmodule
